// File: rtl/amm_pkg.sv
// Shared types and helpers for the Avalon-MM burst splitter and related CDC variants.
package amm_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR_ISSUE,
    WR_DATA,
    RD_ISSUE,
    RD_WAIT
  } amm_split_state_t;

  // Address increment between consecutive beats of an incrementing burst.
  function automatic int unsigned amm_addr_step(input int unsigned d_w, input bit byte_addr);
    return byte_addr ? (d_w / 8) : 1;
  endfunction

endpackage

// File: rtl/amm_burst_splitter.sv
// Re-issues Avalon-MM incrementing bursts as single-beat transfers, one outstanding at a time,
// so a non-bursting single-outstanding CDC stage can serve a bursting master.
module amm_burst_splitter
  import amm_pkg::*;
#(
  parameter int unsigned A_W       = 32,
  parameter int unsigned D_W       = 64,
  parameter int unsigned BURST_W   = 4,
  parameter bit          BYTE_ADDR = 1'b1
) (
  input  logic                 clk_m_i,
  input  logic                 rst_m_i,
  input  logic                 s_read_i,
  input  logic                 s_write_i,
  input  logic [A_W-1:0]       s_address_i,
  input  logic [BURST_W-1:0]   s_burstcount_i,
  input  logic [D_W/8-1:0]     s_byteenable_i,
  input  logic [D_W-1:0]       s_writedata_i,
  output logic                 s_waitrequest_o,
  output logic [D_W-1:0]       s_readdata_o,
  output logic                 s_readdatavalid_o,
  output logic                 m_read_o,
  output logic                 m_write_o,
  output logic [A_W-1:0]       m_address_o,
  output logic [D_W/8-1:0]     m_byteenable_o,
  output logic [D_W-1:0]       m_writedata_o,
  input  logic                 m_waitrequest_i,
  input  logic [D_W-1:0]       m_readdata_i,
  input  logic                 m_readdatavalid_i
);

  localparam logic [A_W-1:0] STEP = A_W'(amm_addr_step(D_W, BYTE_ADDR));

  amm_split_state_t   state, state_nxt;
  logic [BURST_W-1:0] remaining;
  logic [BURST_W-1:0] burst_len;
  logic               last_beat;
  logic               accept_wr, accept_rd, load_wdata, beat_done, rd_beat;

  // A zero burstcount is a single beat.
  assign burst_len = (s_burstcount_i == '0) ? BURST_W'(1) : s_burstcount_i;
  assign last_beat = (remaining == BURST_W'(1));

  assign s_waitrequest_o = (state == WR_ISSUE) || (state == RD_ISSUE) || (state == RD_WAIT);

  always_ff @(posedge clk_m_i or posedge rst_m_i) begin
    if (rst_m_i) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    accept_wr  = 1'b0;
    accept_rd  = 1'b0;
    load_wdata = 1'b0;
    beat_done  = 1'b0;
    rd_beat    = 1'b0;
    unique case (state)
      IDLE: begin
        if (s_write_i) begin
          accept_wr = 1'b1;
          state_nxt = WR_ISSUE;
        end else if (s_read_i) begin
          accept_rd = 1'b1;
          state_nxt = RD_ISSUE;
        end
      end
      WR_ISSUE: begin
        if (!m_waitrequest_i) begin
          beat_done = 1'b1;
          state_nxt = last_beat ? IDLE : WR_DATA;
        end
      end
      WR_DATA: begin
        if (s_write_i) begin
          load_wdata = 1'b1;
          state_nxt  = WR_ISSUE;
        end
      end
      RD_ISSUE: begin
        if (!m_waitrequest_i) state_nxt = RD_WAIT;
      end
      RD_WAIT: begin
        if (m_readdatavalid_i) begin
          beat_done = 1'b1;
          rd_beat   = 1'b1;
          state_nxt = last_beat ? IDLE : RD_ISSUE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Command strobes are registered from the next state so they appear the cycle after acceptance.
  always_ff @(posedge clk_m_i or posedge rst_m_i) begin
    if (rst_m_i) begin
      m_read_o          <= 1'b0;
      m_write_o         <= 1'b0;
      m_address_o       <= '0;
      m_byteenable_o    <= '0;
      m_writedata_o     <= '0;
      s_readdata_o      <= '0;
      s_readdatavalid_o <= 1'b0;
      remaining         <= '0;
    end else begin
      m_write_o         <= (state_nxt == WR_ISSUE);
      m_read_o          <= (state_nxt == RD_ISSUE);
      s_readdatavalid_o <= rd_beat;
      if (rd_beat) s_readdata_o <= m_readdata_i;

      if (accept_wr) begin
        m_address_o    <= s_address_i;
        m_byteenable_o <= s_byteenable_i;
        m_writedata_o  <= s_writedata_i;
        remaining      <= burst_len;
      end else if (accept_rd) begin
        m_address_o    <= s_address_i;
        m_byteenable_o <= '1;
        remaining      <= burst_len;
      end else if (load_wdata) begin
        m_byteenable_o <= s_byteenable_i;
        m_writedata_o  <= s_writedata_i;
      end

      if (beat_done) begin
        remaining <= remaining - BURST_W'(1);
        if (!last_beat) m_address_o <= m_address_o + STEP;
      end
    end
  end

endmodule

// File: tb/tb_amm_burst_splitter.sv
// Scoreboard bench for amm_burst_splitter: master driver, CDC responder model and output monitor.
module tb_amm_burst_splitter;

  localparam int A_W     = 32;
  localparam int D_W     = 64;
  localparam int BURST_W = 4;

  logic               clk = 1'b0;
  logic               rst;
  logic               s_read, s_write;
  logic [A_W-1:0]     s_address;
  logic [BURST_W-1:0] s_burstcount;
  logic [D_W/8-1:0]   s_byteenable;
  logic [D_W-1:0]     s_writedata;
  logic               s_waitrequest;
  logic [D_W-1:0]     s_readdata;
  logic               s_readdatavalid;
  logic               m_read, m_write;
  logic [A_W-1:0]     m_address;
  logic [D_W/8-1:0]   m_byteenable;
  logic [D_W-1:0]     m_writedata;
  logic               m_waitrequest;
  logic [D_W-1:0]     m_readdata;
  logic               m_readdatavalid;

  always #5 clk = ~clk;

  amm_burst_splitter #(.A_W(A_W), .D_W(D_W), .BURST_W(BURST_W), .BYTE_ADDR(1'b1)) dut (
    .clk_m_i(clk), .rst_m_i(rst),
    .s_read_i(s_read), .s_write_i(s_write), .s_address_i(s_address),
    .s_burstcount_i(s_burstcount), .s_byteenable_i(s_byteenable), .s_writedata_i(s_writedata),
    .s_waitrequest_o(s_waitrequest), .s_readdata_o(s_readdata), .s_readdatavalid_o(s_readdatavalid),
    .m_read_o(m_read), .m_write_o(m_write), .m_address_o(m_address),
    .m_byteenable_o(m_byteenable), .m_writedata_o(m_writedata),
    .m_waitrequest_i(m_waitrequest), .m_readdata_i(m_readdata), .m_readdatavalid_i(m_readdatavalid)
  );

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [7:0]  be;
    logic [63:0] data;
  } beat_t;

  beat_t       exp_m[$];
  logic [63:0] exp_rd[$];
  int          vectors = 0;
  int          miscompares = 0;

  // monitor-owned
  bit          rd_acc_evt = 0;
  int unsigned wr_beats = 0, rd_beats = 0;
  // responder-owned
  bit          pending = 0;
  bit          resp_real = 0;
  // driver-owned knobs
  bit          stale = 0;
  bit          in_write = 0;
  int          fixed_delay = 0;
  int          wait_pct = 0;
  int unsigned stall_beat = 32'hFFFF_FFFF;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // Monitor: samples on the falling edge, pops the scoreboard on every accepted beat.
  initial begin
    bit          stalled = 0;
    bit          resp_prev = 0;
    logic [1:0]  held_kind = '0;
    logic [31:0] held_addr = '0;
    beat_t       e;
    logic [63:0] d;
    forever begin
      @(negedge clk);
      if (rst) begin
        stalled = 0; resp_prev = 0; rd_acc_evt = 0;
      end else begin
        chk("s_rdv_timing", 64'(s_readdatavalid), 64'(resp_prev));
        if (resp_prev && exp_rd.size() > 0) begin
          d = exp_rd.pop_front();
          if (s_readdatavalid) chk("s_readdata", s_readdata, d);
        end
        resp_prev = resp_real;
        if (m_read || m_write) chk("s_wait_busy", 64'(s_waitrequest), 64'd1);
        if (stalled) begin
          chk("held_cmd", 64'({m_write, m_read}), 64'(held_kind));
          chk("held_addr", 64'(m_address), 64'(held_addr));
        end
        rd_acc_evt = 0;
        if ((m_read || m_write) && !m_waitrequest) begin
          stalled = 0;
          if (exp_m.size() == 0) chk("unexpected_beat", 64'd1, 64'd0);
          else begin
            e = exp_m.pop_front();
            chk("beat_kind", 64'(m_write), 64'(e.wr));
            chk("beat_addr", 64'(m_address), 64'(e.addr));
            chk("beat_be", 64'(m_byteenable), 64'(e.be));
            if (e.wr) chk("beat_wdata", m_writedata, e.data);
          end
          if (m_read) begin
            chk("one_outstanding", 64'(pending), 64'd0);
            rd_acc_evt = 1;
            rd_beats++;
          end else wr_beats++;
        end else if (m_read || m_write) begin
          stalled = 1; held_kind = {m_write, m_read}; held_addr = m_address;
        end else stalled = 0;
      end
    end
  end

  // CDC responder: one read response per accepted read, stalls and spurious valids on demand.
  initial begin
    int cnt = 0;
    int stall_cnt = 0;
    m_waitrequest = 1'b0; m_readdatavalid = 1'b0; m_readdata = '0;
    forever begin
      @(posedge clk); #1;
      m_readdatavalid = 1'b0;
      resp_real = 0;
      if (rd_acc_evt) begin
        pending = 1;
        cnt = (fixed_delay > 0) ? fixed_delay : int'($urandom_range(1, 4));
      end
      if (pending) begin
        cnt--;
        if (cnt <= 0) begin
          m_readdatavalid = 1'b1;
          m_readdata = {$urandom, $urandom};
          pending = 0;
          if (!stale) begin
            exp_rd.push_back(m_readdata);
            resp_real = 1;
          end
        end
      end else if (in_write && $urandom_range(0, 3) == 0) begin
        m_readdatavalid = 1'b1;
        m_readdata = {$urandom, $urandom};
      end
      if (wr_beats != stall_beat) stall_cnt = 0;
      if (m_write && wr_beats == stall_beat && stall_cnt < 7) begin
        m_waitrequest = 1'b1;
        stall_cnt++;
      end else m_waitrequest = ($urandom_range(0, 99) < wait_pct);
    end
  end

  task automatic accept(string what);
    int n = 0;
    forever begin
      @(negedge clk);
      if (!s_waitrequest) break;
      n++;
      if (n > 500) begin chk({what, "_accept_timeout"}, 64'd1, 64'd0); break; end
    end
    @(posedge clk); #1;
  endtask

  task automatic do_write(logic [31:0] addr, logic [3:0] bc, bit both, bit seq_data);
    int    n = (bc == 0) ? 1 : int'(bc);
    beat_t e;
    for (int i = 0; i < n; i++) begin
      e.wr = 1; e.addr = addr + 32'(i * 8);
      e.be = 8'($urandom);
      e.data = seq_data ? 64'(i) : {$urandom, $urandom};
      exp_m.push_back(e);
      s_write = 1'b1;
      s_read = (i == 0) ? both : 1'($urandom_range(0, 1));
      s_address = addr; s_burstcount = bc;
      s_byteenable = e.be; s_writedata = e.data;
      accept("wr");
      in_write = 1;
      chk("wr_cmd_latency", 64'(m_write), 64'd1);
    end
    s_write = 1'b0; s_read = 1'b0;
    in_write = 0;
  endtask

  task automatic do_read(logic [31:0] addr, logic [3:0] bc);
    int    n = (bc == 0) ? 1 : int'(bc);
    beat_t e;
    for (int i = 0; i < n; i++) begin
      e.wr = 0; e.addr = addr + 32'(i * 8); e.be = 8'hFF; e.data = '0;
      exp_m.push_back(e);
    end
    s_read = 1'b1; s_address = addr; s_burstcount = bc; s_byteenable = 8'($urandom);
    accept("rd");
    chk("rd_cmd_latency", 64'(m_read), 64'd1);
    s_read = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_m.size() != 0 || pending) && n < 3000) begin
      @(posedge clk); n++;
    end
    repeat (2) @(posedge clk);
    #1;
    if (n >= 3000) chk("drain_timeout", 64'd1, 64'd0);
  endtask

  initial begin
    int unsigned base;
    int          n;
    logic [31:0] a;
    rst = 1'b1; s_read = 1'b0; s_write = 1'b0; s_address = '0; s_burstcount = '0;
    s_byteenable = '0; s_writedata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    chk("rst_s_wait", 64'(s_waitrequest), 64'd0);
    chk("rst_m_read", 64'(m_read), 64'd0);
    chk("rst_m_write", 64'(m_write), 64'd0);
    chk("rst_s_rdv", 64'(s_readdatavalid), 64'd0);
    chk("rst_m_addr", 64'(m_address), 64'd0);
    chk("rst_m_wdata", m_writedata, 64'd0);
    @(posedge clk); #1;

    do_write(32'h100, 4'd4, 1'b0, 1'b1);
    fixed_delay = 5;
    do_read(32'h40, 4'd3);
    drain();
    fixed_delay = 0;
    stall_beat = wr_beats + 1;
    do_write(32'h200, 4'd4, 1'b0, 1'b0);
    drain();
    stall_beat = 32'hFFFF_FFFF;
    do_write(32'hFFFF_FFF8, 4'd2, 1'b0, 1'b0);
    do_read(32'h80, 4'd0);
    do_write(32'h300, 4'd1, 1'b1, 1'b0);
    drain();

    // Reset while waiting on the second read response of a four-beat burst.
    fixed_delay = 6;
    base = rd_beats;
    do_read(32'h1000, 4'd4);
    n = 0;
    while (rd_beats < base + 2 && n < 200) begin @(posedge clk); n++; end
    if (n >= 200) chk("rst_test_timeout", 64'd1, 64'd0);
    @(negedge clk); #2;
    rst = 1'b1; stale = 1;
    exp_m.delete();
    #1;
    chk("async_rst_m_read", 64'(m_read), 64'd0);
    chk("async_rst_s_wait", 64'(s_waitrequest), 64'd0);
    chk("async_rst_s_rdv", 64'(s_readdatavalid), 64'd0);
    chk("async_rst_m_addr", 64'(m_address), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    drain();
    chk("late_rsp_dropped", 64'(exp_rd.size()), 64'd0);
    stale = 0; fixed_delay = 0;

    for (int k = 0; k < 60; k++) begin
      wait_pct = 25;
      a = $urandom;
      if ($urandom_range(0, 1) == 1) a[2:0] = 3'b000;
      case ($urandom_range(0, 2))
        0: do_write(a, 4'($urandom_range(0, 15)), 1'b0, 1'b0);
        1: do_read(a, 4'($urandom_range(0, 15)));
        default: do_write(a, 4'($urandom_range(0, 15)), 1'b1, 1'b0);
      endcase
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
    wait_pct = 0;
    drain();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
